// File: rtl/serial_deserializer.sv
// Serial-to-parallel deserializer with a one-word holding register and a sticky overrun flag.
// Define DESER_PARITY_EN to append an even-parity bit to each frame and report parity_err.
module serial_deserializer #(
    parameter int unsigned n = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_valid,
    input  logic         dir,
    output logic [n-1:0] Q,
    output logic         q_valid,
    input  logic         q_ready,
    output logic         overrun,
    output logic         parity_err
);

    localparam int unsigned cw = $clog2(n);
    localparam logic [cw-1:0] cnt_last = cw'(n - 1);

    logic [n-1:0]  sr_q, sr_d;
    logic [cw-1:0] cnt_q, cnt_d;
    logic          fdir_q, fdir_d;
    logic [n-1:0]  q_d;
    logic          q_valid_d, overrun_d;
    logic          frame_start, frame_dir, complete, hold_free;
    logic [n-1:0]  shifted, word;

    // A new frame takes its direction from dir on its very first bit.
    assign frame_dir = frame_start ? dir : fdir_q;
    assign shifted   = frame_dir ? {sin, sr_q[n-1:1]} : {sr_q[n-2:0], sin};
    assign hold_free = !q_valid || q_ready;

`ifdef DESER_PARITY_EN
    typedef enum logic {StCollect, StParity} state_e;
    state_e state_q, state_d;
    logic   perr_q, perr_d, word_perr;

    assign frame_start = (cnt_q == '0) && (state_q == StCollect);
    assign parity_err  = perr_q;

    always_comb begin
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        fdir_d    = fdir_q;
        state_d   = state_q;
        complete  = 1'b0;
        word      = shifted;
        word_perr = 1'b0;
        if (sin_valid) begin
            case (state_q)
                StCollect: begin
                    fdir_d = frame_dir;
                    sr_d   = shifted;
                    if (cnt_q == cnt_last) begin
                        cnt_d   = '0;
                        state_d = StParity;
                    end else begin
                        cnt_d = cnt_q + cw'(1);
                    end
                end
                StParity: begin
                    // Parity bit is checked but never enters the shift register.
                    complete  = 1'b1;
                    word      = sr_q;
                    word_perr = ^sr_q ^ sin;
                    state_d   = StCollect;
                end
                default: state_d = StCollect;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StCollect;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        perr_d = perr_q;
        if (complete && hold_free) perr_d = word_perr;
    end
`else
    assign frame_start = (cnt_q == '0);
    assign parity_err  = 1'b0;

    always_comb begin
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        fdir_d   = fdir_q;
        complete = 1'b0;
        word     = shifted;
        if (sin_valid) begin
            fdir_d = frame_dir;
            sr_d   = shifted;
            if (cnt_q == cnt_last) begin
                cnt_d    = '0;
                complete = 1'b1;
            end else begin
                cnt_d = cnt_q + cw'(1);
            end
        end
    end
`endif

    always_comb begin
        q_d       = Q;
        q_valid_d = q_valid;
        overrun_d = overrun;
        if (complete) begin
            if (hold_free) begin
                q_d       = word;
                q_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (q_valid && q_ready) begin
            q_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            fdir_q  <= 1'b0;
            Q       <= '0;
            q_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            fdir_q  <= fdir_d;
            Q       <= q_d;
            q_valid <= q_valid_d;
            overrun <= overrun_d;
        end
    end

endmodule
